// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the
// command bundle captured on each accepted request.
package apb_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_STRB_W = CMD_DATA_W / 8;

  typedef logic [1:0] apb_state_e;

  localparam apb_state_e IDLE   = 2'd0;
  localparam apb_state_e SETUP  = 2'd1;
  localparam apb_state_e ACCESS = 2'd2;
  localparam apb_state_e RESP   = 2'd3;

  // Sized for the widest legal configuration; narrower
  // instances zero-extend into it and truncate out of it.
  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_cmd_t;

  function automatic logic in_bus_phase(
    input apb_state_e s
  );
    return (s == SETUP) || (s == ACCESS);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive wait-state ACCESS cycles and flags the cycle
// on which the transfer must be abandoned.
module apb_wait_timer #(
  parameter int TIMEOUT = 16,
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // A zero limit means wait forever.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable &&
        (count == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: valid/ready command in, SETUP/ACCESS sequencing
// with wait states, slave error and timeout, valid/ready response out.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [2:0]        pprot,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pwstrb,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              pwakeup
);

  apb_state_e state;
  apb_state_e state_nxt;
  apb_cmd_t   cmd;
  logic       cmd_fire;
  logic       rsp_fire;
  logic       wait_en;
  logic       expired;

  // Reads never drive data or strobes onto the bus.
  always_comb begin
    cmd       = '0;
    cmd.write = cmd_write;
    cmd.addr  = CMD_ADDR_W'(cmd_addr);
    cmd.prot  = cmd_prot;
    if (cmd_write) begin
      cmd.wdata = CMD_DATA_W'(cmd_wdata);
      cmd.strb  = CMD_STRB_W'(cmd_strb);
    end
  end

  assign rsp_fire  = (state == RESP) && rsp_ready;
  assign cmd_ready = presetn &&
    ((state == IDLE) || rsp_fire);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign psel      = in_bus_phase(state);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign wait_en   = (state == ACCESS) && !pready;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE: begin
        if (cmd_fire) state_nxt = SETUP;
      end
      state == SETUP: begin
        state_nxt = ACCESS;
      end
      state == ACCESS: begin
        if (pready || expired) state_nxt = RESP;
      end
      default: begin
        if (rsp_fire) begin
          state_nxt = cmd_fire ? SETUP : IDLE;
        end
      end
    endcase
  end

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (pclk),
    .rst_n   (presetn),
    .clear   (cmd_fire),
    .enable  (wait_en),
    .expired (expired)
  );

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= IDLE;
      paddr       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pwstrb      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      pwakeup     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwakeup <= cmd_valid || (state != IDLE);
      if (cmd_fire) begin
        paddr  <= ADDR_W'(cmd.addr);
        pprot  <= cmd.prot;
        pwrite <= cmd.write;
        pwdata <= DATA_W'(cmd.wdata);
        pwstrb <= STRB_W'(cmd.strb);
      end
      if (state == ACCESS) begin
        if (pready) begin
          rsp_rdata   <= pwrite ? '0 : prdata;
          rsp_err     <= pslverr;
          rsp_timeout <= 1'b0;
        end else if (expired) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: scoreboard-checked responses
// plus cycle-level checks of the APB phases.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pwakeup;

  logic        presetn_z = 1'b0;
  logic        cmd_valid_z = 1'b0;
  logic        cmd_ready_z;
  logic        rsp_valid_z;
  logic [31:0] rsp_rdata_z;
  logic        rsp_err_z;
  logic        rsp_timeout_z;
  logic [15:0] paddr_z;
  logic [2:0]  pprot_z;
  logic        psel_z;
  logic        penable_z;
  logic        pwrite_z;
  logic [31:0] pwdata_z;
  logic [3:0]  pwstrb_z;
  logic        pwakeup_z;

  always #5 pclk = ~pclk;

  apb_requester #(
    .ADDR_W (16), .DATA_W (32), .TIMEOUT (4)
  ) dut (
    .pclk (pclk), .presetn (presetn),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_write (cmd_write), .cmd_addr (cmd_addr),
    .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb),
    .cmd_prot (cmd_prot),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr (paddr), .pprot (pprot), .psel (psel),
    .penable (penable), .pwrite (pwrite),
    .pwdata (pwdata), .pwstrb (pwstrb),
    .pready (pready), .prdata (prdata),
    .pslverr (pslverr), .pwakeup (pwakeup)
  );

  apb_requester #(
    .ADDR_W (16), .DATA_W (32), .TIMEOUT (0)
  ) dut_z (
    .pclk (pclk), .presetn (presetn_z),
    .cmd_valid (cmd_valid_z), .cmd_ready (cmd_ready_z),
    .cmd_write (1'b0), .cmd_addr (16'h0080),
    .cmd_wdata (32'h0), .cmd_strb (4'h0),
    .cmd_prot (3'b000),
    .rsp_valid (rsp_valid_z), .rsp_ready (1'b1),
    .rsp_rdata (rsp_rdata_z), .rsp_err (rsp_err_z),
    .rsp_timeout (rsp_timeout_z),
    .paddr (paddr_z), .pprot (pprot_z), .psel (psel_z),
    .penable (penable_z), .pwrite (pwrite_z),
    .pwdata (pwdata_z), .pwstrb (pwstrb_z),
    .pready (1'b0), .prdata (32'h0),
    .pslverr (1'b0), .pwakeup (pwakeup_z)
  );

  // Completer model: wait_n wait states, or never ready when hung.
  int          wait_n = 0;
  logic        hang = 1'b0;
  logic [31:0] rdata_v = '0;
  logic        err_v = 1'b0;
  int          acc_cnt = 0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready  = psel && penable && !hang &&
                   (acc_cnt == wait_n);
  assign prdata  = rdata_v;
  assign pslverr = err_v && pready;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];

  task automatic expect_rsp(input logic [31:0] d,
                            input logic e,
                            input logic t);
    rsp_t r;
    r.rdata = d;
    r.err   = e;
    r.to    = t;
    exp_q.push_back(r);
  endtask

  always @(negedge pclk) begin
    if (presetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic w,
                       input logic [15:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input logic [2:0] p,
                       output int acc);
    bit got;
    got       = 1'b0;
    acc       = -1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge pclk);
      got = cmd_ready;
      @(posedge pclk);
      #1;
    end
    cmd_valid = 1'b0;
    if (got) acc = cyc;
    else check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    tick(2);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_pwakeup", 32'(pwakeup), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    presetn   = 1'b1;
    presetn_z = 1'b1;
    #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 3'b010, a0);
    check("wr_setup_psel", 32'(psel), 32'd1);
    check("wr_setup_penable", 32'(penable), 32'd0);
    check("wr_paddr", 32'(paddr), 32'h40);
    check("wr_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_pwstrb", 32'(pwstrb), 32'hF);
    check("wr_pwrite", 32'(pwrite), 32'd1);
    check("wr_pprot", 32'(pprot), 32'd2);
    check("wr_pwakeup", 32'(pwakeup), 32'd1);
    tick();
    check("wr_access", 32'({psel, penable}), 32'd3);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_psel", 32'(psel), 32'd0);
    tick();
    check("wr_idle_rsp", 32'(rsp_valid), 32'd0);
    check("wr_paddr_held", 32'(paddr), 32'h40);

    // Read with 3 wait states
    wait_n  = 3;
    rdata_v = 32'hCAFEF00D;
    expect_rsp(32'hCAFEF00D, 1'b0, 1'b0);
    issue(1'b0, 16'h0040, 32'hFFFFFFFF, 4'hF, 3'b000, a0);
    check("rd_pwstrb", 32'(pwstrb), 32'd0);
    check("rd_pwdata", pwdata, 32'd0);
    check("rd_pwrite", 32'(pwrite), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("rd_wait_access", 32'({psel, penable}), 32'd3);
    end
    tick();
    check("rd_rsp_valid_c6", 32'(rsp_valid), 32'd1);
    tick();
    wait_n = 0;

    // Read with slave error
    err_v   = 1'b1;
    rdata_v = 32'h12345678;
    expect_rsp(32'h12345678, 1'b1, 1'b0);
    issue(1'b0, 16'h0044, 32'h0, 4'h0, 3'b001, a0);
    tick(3);
    err_v = 1'b0;

    // Timeout after 4 ACCESS cycles
    hang    = 1'b1;
    rdata_v = 32'h55AA55AA;
    expect_rsp(32'h0, 1'b1, 1'b1);
    issue(1'b0, 16'h0048, 32'h0, 4'h0, 3'b000, a0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("to_access", 32'({psel, penable}), 32'd3);
    end
    tick();
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_psel", 32'(psel), 32'd0);
    hang = 1'b0;
    tick();

    // Back-to-back writes, then stall the response
    expect_rsp(32'h0, 1'b0, 1'b0);
    expect_rsp(32'h0, 1'b0, 1'b0);
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(1'b1, 16'h0100, 32'h11111111, 4'h1, 3'b0, a0);
    check("b2b_setup0", 32'({psel, penable}), 32'd2);
    issue(1'b1, 16'h0104, 32'h22222222, 4'h3, 3'b0, a1);
    check("b2b_setup1", 32'({psel, penable}), 32'd2);
    check("b2b_paddr1", 32'(paddr), 32'h104);
    issue(1'b1, 16'h0108, 32'h33333333, 4'hC, 3'b0, a2);
    check("b2b_setup2", 32'({psel, penable}), 32'd2);
    check("b2b_gap01", 32'(a1 - a0), 32'd3);
    check("b2b_gap12", 32'(a2 - a1), 32'd3);
    rsp_ready = 1'b0;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_rsp_err", 32'(rsp_err), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick(2);

    // Reset during ACCESS
    hang = 1'b1;
    issue(1'b1, 16'h004C, 32'hA5A5A5A5, 4'hF, 3'b111, a0);
    tick();
    check("mid_access", 32'({psel, penable}), 32'd3);
    presetn = 1'b0;
    #1;
    check("mid_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("mr_psel", 32'(psel), 32'd0);
    check("mr_penable", 32'(penable), 32'd0);
    check("mr_pwrite", 32'(pwrite), 32'd0);
    check("mr_paddr", 32'(paddr), 32'd0);
    check("mr_pwdata", pwdata, 32'd0);
    check("mr_pwstrb", 32'(pwstrb), 32'd0);
    check("mr_pprot", 32'(pprot), 32'd0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_rsp_flags", 32'({rsp_err, rsp_timeout}), 32'd0);
    check("mr_rsp_rdata", rsp_rdata, 32'd0);
    check("mr_pwakeup", 32'(pwakeup), 32'd0);
    hang    = 1'b0;
    presetn = 1'b1;
    tick(3);
    check("post_rst_pwakeup", 32'(pwakeup), 32'd0);
    check("post_rst_rsp", 32'(rsp_valid), 32'd0);
    expect_rsp(32'h0, 1'b0, 1'b0);
    issue(1'b1, 16'h0050, 32'h0BADF00D, 4'h5, 3'b0, a0);
    check("wake_pwakeup", 32'(pwakeup), 32'd1);
    check("wake_pwstrb", 32'(pwstrb), 32'h5);
    tick(3);

    // TIMEOUT=0 instance waits indefinitely
    check("z_cmd_ready", 32'(cmd_ready_z), 32'd1);
    cmd_valid_z = 1'b1;
    tick();
    cmd_valid_z = 1'b0;
    tick(20);
    check("z_still_access", 32'({psel_z, penable_z}), 32'd3);
    check("z_no_rsp", 32'(rsp_valid_z), 32'd0);
    presetn_z = 1'b0;
    tick();
    check("z_rst_psel", 32'(psel_z), 32'd0);

    tick(2);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
